// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver. Recovers start, DATA_WIDTH data bits (LSB first),
// optional even/odd parity and one stop bit, using a 3-sample majority vote at mid-bit.
module uart_rx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESC_W-1:0]    Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Parity_Error,
   output logic                  Stop_Error
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
   localparam logic [PRESC_W-1:0]   P_ONE    = PRESC_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                 state_q;
   state_t                 state_d;

   logic [PRESC_W-1:0]     presc_q;
   logic                   par_en_q;
   logic                   par_typ_q;
   logic [PRESC_W-1:0]     edge_cnt;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [2:0]             samples;
   logic [DATA_WIDTH-1:0]  shift_q;

   logic [PRESC_W-1:0]     half;
   logic [PRESC_W-1:0]     samp_lo;
   logic [PRESC_W-1:0]     samp_hi;
   logic [PRESC_W-1:0]     last_edge;
   logic                   bit_end;
   logic                   vote;
   logic                   par_expected;

   // Sample points and bit boundary derive from the Prescale captured at frame start, so any
   // value (even an illegal one) gives a bounded bit time and the FSM always gets back to IDLE.
   assign half         = presc_q >> 1;
   assign samp_lo      = half - P_ONE;
   assign samp_hi      = half + P_ONE;
   assign last_edge    = presc_q - P_ONE;
   assign bit_end      = (edge_cnt == last_edge);
   assign vote         = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);
   assign par_expected = (^shift_q) ^ par_typ_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = vote ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_end && (bit_cnt == LAST_BIT)) begin
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Frame configuration is captured on the same edge that leaves IDLE.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         edge_cnt  <= '0;
         bit_cnt   <= '0;
         samples   <= '0;
         shift_q   <= '0;
      end else if (state_q == IDLE) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
         samples  <= '0;
         if (!RX_IN) begin
            presc_q   <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
         end
      end else begin
         if (bit_end) begin
            edge_cnt <= '0;
         end else begin
            edge_cnt <= edge_cnt + P_ONE;
         end
         if (edge_cnt == samp_lo) begin
            samples[0] <= RX_IN;
         end
         if (edge_cnt == half) begin
            samples[1] <= RX_IN;
         end
         if (edge_cnt == samp_hi) begin
            samples[2] <= RX_IN;
         end
         if ((state_q == DATA) && bit_end) begin
            shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_ONE;
         end
      end
   end

   // Error flags hold until the next start bit; P_DATA only moves on an error-free frame.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         P_DATA       <= '0;
         Data_Valid   <= 1'b0;
         Parity_Error <= 1'b0;
         Stop_Error   <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!RX_IN) begin
                  Parity_Error <= 1'b0;
                  Stop_Error   <= 1'b0;
               end
            end
            PARITY: begin
               if (bit_end && (vote != par_expected)) begin
                  Parity_Error <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (!vote) begin
                     Stop_Error <= 1'b1;
                  end else if (!Parity_Error) begin
                     P_DATA     <= shift_q;
                     Data_Valid <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core; frames are driven bit by bit and every
// word the receiver reports is matched against the words expected from the driven frames.
module tb_uart_rx_core;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Parity_Error;
   logic       Stop_Error;

   int         n_compared;
   int         n_mismatched;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   logic [7:0] last_good;

   uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .Prescale     (Prescale),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .P_DATA       (P_DATA),
      .Data_Valid   (Data_Valid),
      .Parity_Error (Parity_Error),
      .Stop_Error   (Stop_Error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Every reported word lands in obs_q, sampled on the falling edge.
   always @(negedge CLK) begin
      if (RST === 1'b1 && Data_Valid === 1'b1) begin
         obs_q.push_back(P_DATA);
      end
   end

   task automatic send_bit(input logic b, input int p);
      RX_IN = b;
      repeat (p) @(negedge CLK);
   endtask

   task automatic send_tail(input logic [7:0] data, input logic with_par, input logic par_bit,
                            input logic stop_bit, input int p);
      for (int i = 0; i < 8; i++) begin
         send_bit(data[i], p);
      end
      if (with_par) begin
         send_bit(par_bit, p);
      end
      send_bit(stop_bit, p);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                             input logic stop_bit, input int p);
      send_bit(1'b0, p);
      send_tail(data, with_par, par_bit, stop_bit, p);
   endtask

   task automatic configure(input int p, input logic pen, input logic ptyp);
      Prescale = p[5:0];
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
   endtask

   task automatic wait_obs(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (obs_q.size() >= n) break;
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      RST   = 1'b0;
      RX_IN = 1'b1;
      configure(8, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      n_compared++;
      if (P_DATA !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL reset_pdata: got %h, expected 00", P_DATA);
      end
      n_compared++;
      if (Data_Valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_valid: got %b, expected 0", Data_Valid);
      end
      n_compared++;
      if (Parity_Error !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_perr: got %b, expected 0", Parity_Error);
      end
      n_compared++;
      if (Stop_Error !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_serr: got %b, expected 0", Stop_Error);
      end
      RST = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_parity_good();
      logic [7:0] got;
      logic [7:0] want;
      configure(8, 1'b1, 1'b0);
      exp_q.push_back(8'hA5);
      last_good = 8'hA5;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
      @(negedge CLK);
      n_compared++;
      if (Data_Valid !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL par_good_latency: got %b, expected 1", Data_Valid);
      end
      @(negedge CLK);
      n_compared++;
      if (Data_Valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL par_good_pulse_width: got %b, expected 0", Data_Valid);
      end
      wait_obs(1, 16);
      n_compared++;
      if (obs_q.size() !== 1) begin
         n_mismatched++;
         $display("[TB] FAIL par_good_count: got %0d, expected 1", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         n_compared++;
         if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL par_good_data: got %h, expected %h", got, want);
         end
      end
      n_compared++;
      if ({Parity_Error, Stop_Error} !== 2'b00) begin
         n_mismatched++;
         $display("[TB] FAIL par_good_flags: got %b, expected 00", {Parity_Error, Stop_Error});
      end
      obs_q.delete();
      exp_q.delete();
      repeat (16) @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      logic [7:0] want;
      configure(16, 1'b0, 1'b0);
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h7E);
      last_good = 8'h7E;
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16);
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 16);
      RX_IN = 1'b1;
      wait_obs(2, 64);
      n_compared++;
      if (obs_q.size() !== 2) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_count: got %0d, expected 2", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         n_compared++;
         if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_data: got %h, expected %h", got, want);
         end
      end
      n_compared++;
      if ({Parity_Error, Stop_Error} !== 2'b00) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_flags: got %b, expected 00", {Parity_Error, Stop_Error});
      end
      obs_q.delete();
      exp_q.delete();
      repeat (32) @(negedge CLK);
   endtask

   task automatic test_glitch();
      configure(8, 1'b0, 1'b0);
      RX_IN = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (24) @(negedge CLK);
      n_compared++;
      if (obs_q.size() !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_no_valid: got %0d words, expected 0", obs_q.size());
      end
      n_compared++;
      if (P_DATA !== last_good) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_pdata: got %h, expected %h", P_DATA, last_good);
      end
      n_compared++;
      if ({Parity_Error, Stop_Error} !== 2'b00) begin
         n_mismatched++;
         $display("[TB] FAIL glitch_flags: got %b, expected 00", {Parity_Error, Stop_Error});
      end
      obs_q.delete();
   endtask

   task automatic test_parity_error();
      configure(32, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 32);
      RX_IN = 1'b1;
      repeat (8) @(negedge CLK);
      n_compared++;
      if (Parity_Error !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL par_err_flag: got %b, expected 1", Parity_Error);
      end
      n_compared++;
      if (Stop_Error !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL par_err_stop: got %b, expected 0", Stop_Error);
      end
      n_compared++;
      if (obs_q.size() !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL par_err_no_valid: got %0d words, expected 0", obs_q.size());
      end
      n_compared++;
      if (P_DATA !== last_good) begin
         n_mismatched++;
         $display("[TB] FAIL par_err_pdata: got %h, expected %h", P_DATA, last_good);
      end
      obs_q.delete();
      repeat (16) @(negedge CLK);
   endtask

   task automatic test_stop_error();
      logic [7:0] got;
      logic [7:0] want;
      configure(8, 1'b0, 1'b0);
      send_bit(1'b0, 8);
      n_compared++;
      if (Parity_Error !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL stop_err_perr_cleared: got %b, expected 0", Parity_Error);
      end
      send_tail(8'h55, 1'b0, 1'b0, 1'b0, 8);
      RX_IN = 1'b1;
      repeat (3) @(negedge CLK);
      n_compared++;
      if (Stop_Error !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL stop_err_flag: got %b, expected 1", Stop_Error);
      end
      n_compared++;
      if (obs_q.size() !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL stop_err_no_valid: got %0d words, expected 0", obs_q.size());
      end
      n_compared++;
      if (P_DATA !== last_good) begin
         n_mismatched++;
         $display("[TB] FAIL stop_err_pdata: got %h, expected %h", P_DATA, last_good);
      end
      obs_q.delete();
      repeat (8) @(negedge CLK);
      exp_q.push_back(8'hC3);
      last_good = 8'hC3;
      send_bit(1'b0, 8);
      n_compared++;
      if (Stop_Error !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL stop_err_cleared: got %b, expected 0", Stop_Error);
      end
      send_tail(8'hC3, 1'b0, 1'b0, 1'b1, 8);
      RX_IN = 1'b1;
      wait_obs(1, 16);
      n_compared++;
      if (obs_q.size() !== 1) begin
         n_mismatched++;
         $display("[TB] FAIL stop_recover_count: got %0d, expected 1", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         n_compared++;
         if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL stop_recover_data: got %h, expected %h", got, want);
         end
      end
      obs_q.delete();
      exp_q.delete();
      repeat (16) @(negedge CLK);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] got;
      logic [7:0] want;
      logic [7:0] aborted;
      aborted = 8'h0F;
      configure(8, 1'b0, 1'b0);
      send_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) begin
         send_bit(aborted[i], 8);
      end
      RX_IN = aborted[4];
      repeat (4) @(negedge CLK);
      RST = 1'b0;
      #1;
      n_compared++;
      if ({P_DATA, Data_Valid, Parity_Error, Stop_Error} !== 11'h000) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_reset_outputs: got pdata=%h dv=%b pe=%b se=%b, expected all 0",
                  P_DATA, Data_Valid, Parity_Error, Stop_Error);
      end
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      RST   = 1'b1;
      repeat (16) @(negedge CLK);
      n_compared++;
      if (obs_q.size() !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_no_valid: got %0d words, expected 0", obs_q.size());
      end
      obs_q.delete();
      exp_q.push_back(8'hF0);
      last_good = 8'hF0;
      send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 8);
      RX_IN = 1'b1;
      wait_obs(1, 16);
      n_compared++;
      if (obs_q.size() !== 1) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_recover_count: got %0d, expected 1", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         n_compared++;
         if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL midframe_recover_data: got %h, expected %h", got, want);
         end
      end
      obs_q.delete();
      exp_q.delete();
      repeat (16) @(negedge CLK);
   endtask

   task automatic test_random_parity();
      logic [7:0] got;
      logic [7:0] want;
      logic [7:0] data;
      logic       typ;
      typ = 1'($urandom_range(0, 1));
      configure(16, 1'b1, typ);
      for (int f = 0; f < 4; f++) begin
         data = 8'($urandom_range(0, 255));
         exp_q.push_back(data);
         send_frame(data, 1'b1, (^data) ^ typ, 1'b1, 16);
      end
      RX_IN = 1'b1;
      wait_obs(4, 64);
      n_compared++;
      if (obs_q.size() !== 4) begin
         n_mismatched++;
         $display("[TB] FAIL rand_count: got %0d, expected 4 (par_typ=%b)", obs_q.size(), typ);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got  = obs_q.pop_front();
         want = exp_q.pop_front();
         n_compared++;
         if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL rand_data: got %h, expected %h (par_typ=%b)", got, want, typ);
         end
      end
      n_compared++;
      if ({Parity_Error, Stop_Error} !== 2'b00) begin
         n_mismatched++;
         $display("[TB] FAIL rand_flags: got %b, expected 00", {Parity_Error, Stop_Error});
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      last_good    = 8'h00;
      RST          = 1'b0;
      RX_IN        = 1'b1;
      Prescale     = 6'd8;
      PAR_EN       = 1'b0;
      PAR_TYP      = 1'b0;
      @(negedge CLK);
      test_reset();
      test_parity_good();
      test_back_to_back();
      test_glitch();
      test_parity_error();
      test_stop_error();
      test_reset_mid_frame();
      test_random_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
